// File: rtl/traffic_pkg.sv
// Shared definitions for the multi-channel traffic-light controller:
// state encoding, default timing constants and a parameter sanity helper.
package traffic_pkg;

  typedef enum logic [1:0] {
    S_MAIN_GRN = 2'd0,
    S_YLW      = 2'd1,
    S_ALLRED   = 2'd2,
    S_SIDE_GRN = 2'd3
  } state_t;

  // Default timing, in 1 ms system-clock cycles.
  localparam int DEF_N_CH     = 4;
  localparam int DEF_CNT_W    = 16;
  localparam int DEF_MAIN_MIN = 10000;
  localparam int DEF_SIDE_MIN = 3000;
  localparam int DEF_SIDE_MAX = 8000;
  localparam int DEF_YLW_T    = 3000;
  localparam int DEF_ALLRED_T = 1000;
  localparam int DEF_CH_W     = 2;

  // A phase length is usable when it is non-zero and representable in a
  // timer of the given width.
  function automatic bit time_fits(input int t, input int w);
    longint lim;
    lim = longint'(1) << w;
    return (t > 0) && (longint'(t) < lim);
  endfunction

endpackage

// File: rtl/tl_rr_arbiter.sv
// Round-robin arbiter over the side roads (channels 1..N_CH-1).
// The search starts just after rr_ptr and wraps back to channel 1;
// channel 0 (main road) is never a candidate.
module tl_rr_arbiter
  import traffic_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int CH_W = DEF_CH_W
) (
  input  logic [N_CH-1:0] pending,
  input  logic [CH_W-1:0] rr_ptr,
  output logic [CH_W-1:0] grant,
  output logic            valid
);

  logic            found_hi_s;
  logic [CH_W-1:0] grant_hi_s;
  logic            found_lo_s;
  logic [CH_W-1:0] grant_lo_s;
  logic            unused_s;

  // Bit 0 is the main road and takes no part in arbitration.
  assign unused_s = pending[0];

  // Two-pass search: first channels above rr_ptr, then the wrap-around part.
  always_comb begin
    found_hi_s = 1'b0;
    grant_hi_s = '0;
    found_lo_s = 1'b0;
    grant_lo_s = '0;
    for (int j = 1; j < N_CH; j++) begin
      if (!found_hi_s && pending[j] && (CH_W'(j) > rr_ptr)) begin
        found_hi_s = 1'b1;
        grant_hi_s = CH_W'(j);
      end else begin
        found_hi_s = found_hi_s;
      end
      if (!found_lo_s && pending[j] && (CH_W'(j) <= rr_ptr)) begin
        found_lo_s = 1'b1;
        grant_lo_s = CH_W'(j);
      end else begin
        found_lo_s = found_lo_s;
      end
    end
    if (found_hi_s) begin
      grant = grant_hi_s;
    end else begin
      grant = grant_lo_s;
    end
    valid = found_hi_s | found_lo_s;
  end

endmodule

// File: rtl/traffic_lights_multi.sv
// Traffic-light controller: main road rests on green, latched side-road
// requests are served round-robin, each hand-over goes through yellow and
// all-red clearance, and side green is stretched while a car is present.
module traffic_lights_multi
  import traffic_pkg::*;
#(
  parameter int N_CH     = DEF_N_CH,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int MAIN_MIN = DEF_MAIN_MIN,
  parameter int SIDE_MIN = DEF_SIDE_MIN,
  parameter int SIDE_MAX = DEF_SIDE_MAX,
  parameter int YLW_T    = DEF_YLW_T,
  parameter int ALLRED_T = DEF_ALLRED_T,
  parameter int CH_W     = DEF_CH_W
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [N_CH-1:0] CAR,
  output logic [N_CH-1:0] GRN,
  output logic [N_CH-1:0] YLW,
  output logic [N_CH-1:0] RED,
  output logic [CH_W-1:0] ACTIVE_CH,
  output logic [N_CH-1:0] PENDING
);

  // Reject configurations the controller cannot honour.
  if ((N_CH < 2) || (CH_W < $clog2(N_CH)) || (SIDE_MIN > SIDE_MAX) ||
      !time_fits(MAIN_MIN, CNT_W) || !time_fits(SIDE_MIN, CNT_W) ||
      !time_fits(SIDE_MAX, CNT_W) || !time_fits(YLW_T, CNT_W) ||
      !time_fits(ALLRED_T, CNT_W)) begin : g_bad_params
    $fatal(1, "traffic_lights_multi: illegal parameter set");
  end

  // Last timer value of each phase (phase of length T ends at T-1).
  localparam logic [CNT_W-1:0] MAIN_LAST   = CNT_W'(MAIN_MIN - 1);
  localparam logic [CNT_W-1:0] SIDE_LAST   = CNT_W'(SIDE_MIN - 1);
  localparam logic [CNT_W-1:0] SMAX_LAST   = CNT_W'(SIDE_MAX - 1);
  localparam logic [CNT_W-1:0] YLW_LAST    = CNT_W'(YLW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);

  state_t            state_q, state_d;
  logic [CH_W-1:0]   cur_q, cur_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [N_CH-1:0]   pending_q, pending_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic [CH_W-1:0]   arb_grant_s;
  logic              arb_valid_s;
  logic [N_CH-1:0]   cur_oh_s;
  logic              car_cur_s;
  logic              unused_car0_s;

  // CAR[0] belongs to the main road, which never needs to request.
  assign unused_car0_s = CAR[0];

  tl_rr_arbiter #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_arb (
    .pending (pending_q),
    .rr_ptr  (rr_ptr_q),
    .grant   (arb_grant_s),
    .valid   (arb_valid_s)
  );

  // One-hot of the current owner and the sensor of that owner.
  always_comb begin
    cur_oh_s  = '0;
    car_cur_s = 1'b0;
    for (int i = 1; i < N_CH; i++) begin
      if (cur_q == CH_W'(i)) begin
        cur_oh_s[i] = 1'b1;
        car_cur_s   = CAR[i];
      end else begin
        cur_oh_s[i] = 1'b0;
      end
    end
    cur_oh_s[0] = (cur_q == '0);
  end

  // Next-state, phase timer, request latch and round-robin pointer.
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    rr_ptr_d  = rr_ptr_q;
    timer_d   = timer_q + CNT_W'(1);
    pending_d = pending_q;

    // Latch side-road requests; the channel being served cannot re-request.
    for (int i = 1; i < N_CH; i++) begin
      if (CAR[i] && !((state_q == S_SIDE_GRN) && (cur_q == CH_W'(i)))) begin
        pending_d[i] = 1'b1;
      end else begin
        pending_d[i] = pending_d[i];
      end
    end

    case (state_q)
      S_MAIN_GRN: begin
        if (timer_q >= MAIN_LAST) begin
          if (|pending_q) begin
            state_d = S_YLW;
            timer_d = '0;
          end else begin
            timer_d = MAIN_LAST;
          end
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      S_YLW: begin
        if (timer_q >= YLW_LAST) begin
          state_d = S_ALLRED;
          timer_d = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      S_ALLRED: begin
        if (timer_q >= ALLRED_LAST) begin
          timer_d = '0;
          if ((cur_q == '0) && arb_valid_s) begin
            state_d  = S_SIDE_GRN;
            cur_d    = arb_grant_s;
            rr_ptr_d = arb_grant_s;
            // A grant wins over a same-cycle request from the same channel.
            for (int j = 1; j < N_CH; j++) begin
              if (arb_grant_s == CH_W'(j)) begin
                pending_d[j] = 1'b0;
              end else begin
                pending_d[j] = pending_d[j];
              end
            end
          end else begin
            state_d = S_MAIN_GRN;
            cur_d   = '0;
          end
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      S_SIDE_GRN: begin
        if (((timer_q >= SIDE_LAST) && !car_cur_s) || (timer_q >= SMAX_LAST)) begin
          state_d = S_YLW;
          timer_d = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_MAIN_GRN;
        cur_d   = '0;
        timer_d = '0;
      end
    endcase

    pending_d[0] = 1'b0;
  end

  // State registers; reset returns straight to main green with no yellow owed.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_MAIN_GRN;
      cur_q     <= '0;
      timer_q   <= '0;
      pending_q <= '0;
      rr_ptr_q  <= CH_W'(N_CH - 1);
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  // Moore lamp decode: exactly one lamp per channel, red unless lit otherwise.
  always_comb begin
    GRN = '0;
    YLW = '0;
    case (state_q)
      S_MAIN_GRN: GRN = cur_oh_s;
      S_SIDE_GRN: GRN = cur_oh_s;
      S_YLW:      YLW = cur_oh_s;
      S_ALLRED:   GRN = '0;
      default:    GRN = '0;
    endcase
    RED       = ~(GRN | YLW);
    ACTIVE_CH = cur_q;
    PENDING   = pending_q;
  end

endmodule

// File: tb/tb_traffic_lights_multi.sv
// Self-checking bench for traffic_lights_multi (N_CH=3, short timings):
// a directed vector table, hand-written corner sequences and a randomized
// run against a phase/age reference model.
module tb_traffic_lights_multi;

  localparam int N_CH = 3, MAIN_MIN = 8, SIDE_MIN = 4, SIDE_MAX = 10;
  localparam int YLW_T = 3, ALLRED_T = 2, CH_W = 2;

  logic            Clock = 1'b0;
  logic            Reset = 1'b0;
  logic [2:0]      CAR = 3'b000;
  logic [2:0]      GRN, YLW, RED, PENDING;
  logic [1:0]      ACTIVE_CH;

  int n_tests = 0;
  int n_fail  = 0;

  traffic_lights_multi #(
    .N_CH(N_CH), .CNT_W(16), .MAIN_MIN(MAIN_MIN), .SIDE_MIN(SIDE_MIN),
    .SIDE_MAX(SIDE_MAX), .YLW_T(YLW_T), .ALLRED_T(ALLRED_T), .CH_W(CH_W)
  ) dut (
    .Clock(Clock), .Reset(Reset), .CAR(CAR), .GRN(GRN), .YLW(YLW),
    .RED(RED), .ACTIVE_CH(ACTIVE_CH), .PENDING(PENDING)
  );

  always #5 Clock = ~Clock;

  function automatic logic [13:0] dut_out();
    return {ACTIVE_CH, PENDING, RED, YLW, GRN};
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Phases: "M" main green, "A" amber, "C" clearance, "S" side green.
  // m_age = cycles already spent in the phase.
  byte        m_ph;
  int         m_age, m_own, m_last;
  logic [2:0] m_pend;

  task automatic model_reset();
    m_ph = "M"; m_age = 0; m_own = 0; m_last = N_CH - 1; m_pend = 3'b000;
  endtask

  task automatic model_step(input logic [2:0] car);
    logic [2:0] np;
    int c;
    np = m_pend;
    for (int i = 1; i < N_CH; i++)
      if (car[i] && !(m_ph == "S" && m_own == i)) np[i] = 1'b1;
    m_age++;
    case (m_ph)
      "M": if (m_age >= MAIN_MIN && m_pend != 3'b000) begin m_ph = "A"; m_age = 0; end
      "A": if (m_age == YLW_T) begin m_ph = "C"; m_age = 0; end
      "C": if (m_age == ALLRED_T) begin
             m_age = 0;
             if (m_own == 0) begin
               for (int k = 1; k < N_CH; k++) begin
                 c = m_last + k;
                 if (c > N_CH - 1) c -= (N_CH - 1);
                 if (m_pend[c]) begin
                   m_own = c; m_last = c; np[c] = 1'b0; m_ph = "S";
                   break;
                 end
               end
             end else begin
               m_own = 0; m_ph = "M";
             end
           end
      "S": if ((m_age >= SIDE_MIN && !car[m_own]) || m_age == SIDE_MAX) begin
             m_ph = "A"; m_age = 0;
           end
      default: ;
    endcase
    np[0] = 1'b0;
    m_pend = np;
  endtask

  function automatic logic [13:0] model_out();
    logic [2:0] g, y, own;
    own = 3'b001 << m_own;
    g = (m_ph == "M" || m_ph == "S") ? own : 3'b000;
    y = (m_ph == "A") ? own : 3'b000;
    return {2'(m_own), m_pend, ~(g | y), y, g};
  endfunction

  // ---------------- helpers ----------------
  task automatic do_reset(input int n);
    @(negedge Clock);
    Reset = 1'b0;
    CAR   = 3'b000;
    repeat (n) @(negedge Clock);
    Reset = 1'b1;
  endtask

  task automatic wait_grn(input logic [2:0] mask, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if ((GRN & mask) != 3'b000) begin ok = 1'b1; break; end
      @(negedge Clock);
    end
  endtask

  task automatic count_grn(input logic [2:0] mask, input int ch_hold, output int len);
    len = 0;
    for (int i = 0; i < 40; i++) begin
      if (GRN != mask) break;
      len++;
      CAR = (len <= ch_hold) ? mask : 3'b000;
      @(negedge Clock);
    end
    CAR = 3'b000;
  endtask

  typedef struct {
    logic [2:0] car;
    int         cycles;
    logic [1:0] act;
    logic [2:0] pend, red, ylw, grn;
  } vec_t;

  vec_t tbl[13];
  bit   ok;
  int   len, bad;
  logic [2:0] rcar;

  initial begin
    // Single CAR[1] pulse: full service round, checked at phase boundaries.
    tbl[0]  = '{3'b000, 0, 2'd0, 3'b000, 3'b110, 3'b000, 3'b001};
    tbl[1]  = '{3'b000, 2, 2'd0, 3'b000, 3'b110, 3'b000, 3'b001};
    tbl[2]  = '{3'b010, 1, 2'd0, 3'b010, 3'b110, 3'b000, 3'b001};
    tbl[3]  = '{3'b000, 4, 2'd0, 3'b010, 3'b110, 3'b000, 3'b001};
    tbl[4]  = '{3'b000, 1, 2'd0, 3'b010, 3'b110, 3'b001, 3'b000};
    tbl[5]  = '{3'b000, 2, 2'd0, 3'b010, 3'b110, 3'b001, 3'b000};
    tbl[6]  = '{3'b000, 1, 2'd0, 3'b010, 3'b111, 3'b000, 3'b000};
    tbl[7]  = '{3'b000, 2, 2'd1, 3'b000, 3'b101, 3'b000, 3'b010};
    tbl[8]  = '{3'b000, 3, 2'd1, 3'b000, 3'b101, 3'b000, 3'b010};
    tbl[9]  = '{3'b000, 1, 2'd1, 3'b000, 3'b101, 3'b010, 3'b000};
    tbl[10] = '{3'b000, 3, 2'd1, 3'b000, 3'b111, 3'b000, 3'b000};
    tbl[11] = '{3'b000, 1, 2'd1, 3'b000, 3'b111, 3'b000, 3'b000};
    tbl[12] = '{3'b000, 1, 2'd0, 3'b000, 3'b110, 3'b000, 3'b001};

    // 1. Idle: reset held 10 cycles, then 50 quiet cycles on main green.
    @(negedge Clock);
    Reset = 1'b0;
    repeat (5) @(negedge Clock);
    chk("reset_state", dut_out(), {2'd0, 3'b000, 3'b110, 3'b000, 3'b001});
    repeat (5) @(negedge Clock);
    Reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (dut_out() !== {2'd0, 3'b000, 3'b110, 3'b000, 3'b001}) bad++;
      @(negedge Clock);
    end
    chk("idle_main_green", 16'(bad), 16'd0);

    // 2. Vector table.
    do_reset(3);
    for (int v = 0; v < 13; v++) begin
      CAR = tbl[v].car;
      repeat (tbl[v].cycles) @(negedge Clock);
      chk($sformatf("vec%0d", v), dut_out(),
          {tbl[v].act, tbl[v].pend, tbl[v].red, tbl[v].ylw, tbl[v].grn});
    end

    // 3. CAR[1] held: side green capped at SIDE_MAX, request re-latched in yellow.
    do_reset(3);
    CAR = 3'b010;
    wait_grn(3'b010, 60, ok);
    chk("held_side_reached", 16'(ok), 16'd1);
    count_grn(3'b010, 100, len);
    CAR = 3'b010;
    chk("held_side_len", 16'(len), 16'(SIDE_MAX));
    chk("held_ylw", 16'(YLW), 16'b010);
    @(negedge Clock);
    chk("held_relatch", 16'(PENDING), 16'b010);
    CAR = 3'b000;
    wait_grn(3'b001, 20, ok);
    count_grn(3'b001, 0, len);
    chk("held_main_len", 16'(len), 16'(MAIN_MIN));
    wait_grn(3'b010, 20, ok);
    chk("held_reserved", 16'(ok), 16'd1);

    // 4. Simultaneous requests, two rounds: 1 then 2 each time.
    do_reset(3);
    for (int r = 0; r < 2; r++) begin
      CAR = 3'b110;
      @(negedge Clock);
      CAR = 3'b000;
      wait_grn(3'b110, 60, ok);
      chk($sformatf("pair%0d_first", r), {14'(ok), ACTIVE_CH}, {14'd1, 2'd1});
      wait_grn(3'b001, 60, ok);
      count_grn(3'b001, 0, len);
      chk($sformatf("pair%0d_main", r), 16'(len), 16'(MAIN_MIN));
      wait_grn(3'b110, 60, ok);
      chk($sformatf("pair%0d_second", r), {14'(ok), ACTIVE_CH}, {14'd1, 2'd2});
      wait_grn(3'b001, 60, ok);
    end

    // 5. Side green extension: minimum, then stretched by a held sensor.
    do_reset(3);
    CAR = 3'b100;
    @(negedge Clock);
    CAR = 3'b000;
    wait_grn(3'b100, 60, ok);
    count_grn(3'b100, 0, len);
    chk("side_min_len", 16'(len), 16'(SIDE_MIN));
    wait_grn(3'b001, 60, ok);
    CAR = 3'b100;
    @(negedge Clock);
    CAR = 3'b000;
    wait_grn(3'b100, 60, ok);
    count_grn(3'b100, 6, len);
    chk("side_ext_len", 16'(len), 16'd7);

    // 6. Asynchronous reset in the middle of side green.
    do_reset(3);
    CAR = 3'b010;
    @(negedge Clock);
    CAR = 3'b000;
    wait_grn(3'b010, 60, ok);
    CAR = 3'b100;
    @(negedge Clock);
    CAR = 3'b000;
    chk("mid_side_pending", {13'(PENDING), GRN}, {13'b100, 3'b010});
    #1 Reset = 1'b0;
    #1 chk("async_reset", {11'(ACTIVE_CH), PENDING, GRN}, {11'd0, 3'b000, 3'b001});
    @(negedge Clock);
    Reset = 1'b1;
    len = 0;
    for (int i = 0; i < 40; i++) begin
      if (GRN != 3'b001) break;
      len++;
      CAR = (i == 0) ? 3'b100 : 3'b000;
      @(negedge Clock);
    end
    CAR = 3'b000;
    chk("post_reset_main_len", 16'(len), 16'(MAIN_MIN));

    // 7. Randomized run against the reference model.
    do_reset(3);
    model_reset();
    rcar = 3'b000;
    for (int i = 0; i < 3000; i++) begin
      chk($sformatf("rand%0d", i), 16'(dut_out()), 16'(model_out()));
      for (int b = 1; b < N_CH; b++)
        if ($urandom_range(0, 7) == 0) rcar[b] = ~rcar[b];
      rcar[0] = 1'($urandom_range(0, 1));
      CAR = rcar;
      model_step(rcar);
      @(negedge Clock);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
